isqrt_iter_fsm: RTL and testbench

ISQRT_ITER_FSM -- requirements
Module: isqrt_iter_fsm

---
 rtl/isqrt_iter_fsm.sv | 128 ++++++++++++
 tb/tb_isqrt_iter_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_iter_fsm.sv
// Iterative integer square root: restoring digit-by-digit, one root bit per cycle,
// fronted by a 4-entry in-order request queue with drop-on-full.
//
// state | meaning
// IDLE  | no request in flight, waiting for an operand
// CALC  | 16 iteration cycles, one root bit resolved per cycle (iter 0..15)
// DONE  | result presented on y with y_vld for one cycle
module isqrt_iter_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y,
  output logic        busy,
  output logic        drop
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  iter_q, iter_d;
  logic [31:0] rad_q, rad_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [15:0] y_q, y_d;

  logic [31:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  cnt_q;

  logic        q_empty, q_full, ready, req;
  logic        push, pop, wr_en, start;
  logic [31:0] operand;

  logic [19:0] rem_sh, trial;
  logic        ge;
  logic [17:0] rem_nx;
  logic [15:0] root_nx;

  assign q_empty = (cnt_q == 3'd0);
  assign q_full  = (cnt_q == 3'd4);
  assign ready   = (state_q != S_CALC);
  assign req     = x_vld && !rst;

  // Queue head has priority over a new arrival so ordering is preserved.
  assign pop     = ready && !q_empty;
  assign push    = req && (!ready || !q_empty);
  assign drop    = push && q_full && !pop;
  assign wr_en   = push && !drop;
  assign start   = pop || (ready && q_empty && req);
  assign operand = pop ? fifo_q[rd_ptr_q] : x;

  // Remainder never exceeds 2*root, so 18 bits hold it after each step.
  assign rem_sh  = {rem_q, rad_q[31:30]};
  assign trial   = {2'b00, root_q, 2'b01};
  assign ge      = (rem_sh >= trial);
  assign rem_nx  = ge ? 18'(rem_sh - trial) : rem_sh[17:0];
  assign root_nx = {root_q[14:0], ge};

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CALC;
          iter_d  = 4'd0;
          rad_d   = operand;
          rem_d   = 18'd0;
          root_d  = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rad_d  = {rad_q[29:0], 2'b00};
        rem_d  = rem_nx;
        root_d = root_nx;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = S_DONE;
          y_d     = root_nx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      iter_q   <= 4'd0;
      rad_q    <= 32'd0;
      rem_q    <= 18'd0;
      root_q   <= 16'd0;
      y_q      <= 16'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      y_q      <= y_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 2'd1;
      cnt_q    <= cnt_q + {2'b00, wr_en} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q] <= x;
  end

  assign y_vld = (state_q == S_DONE);
  assign y     = y_q;
  assign busy  = (state_q != S_IDLE) || !q_empty;

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Directed and randomized checks for isqrt_iter_fsm: latency, ordering, queue
// full/drop behaviour, reset abort and floor(sqrt) accuracy.
module tb_isqrt_iter_fsm;

  logic        clk = 1'b0;
  logic        rst, x_vld;
  logic [31:0] x;
  logic        y_vld, busy, drop;
  logic [15:0] y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] res_y  [$];
  int          res_c  [$];
  int          drop_c [$];
  int          sent_c [$];
  logic [15:0] exp_y  [$];

  isqrt_iter_fsm dut (
    .clk   (clk),
    .rst   (rst),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y),
    .busy  (busy),
    .drop  (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (y_vld) begin
      res_y.push_back(y);
      res_c.push_back(cyc);
    end
    if (drop) drop_c.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
    logic [63:0] r, t;
    r = 64'd0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, v}) r = t;
    end
    return r[15:0];
  endfunction

  function automatic logic [63:0] got_y(input int i);
    return (i < res_y.size()) ? {48'd0, res_y[i]} : 64'hDEAD_DEAD;
  endfunction

  function automatic logic [63:0] got_lat(input int i);
    return (i < res_c.size() && sent_c.size() > 0) ? 64'(res_c[i] - sent_c[0]) : 64'hDEAD_DEAD;
  endfunction

  task automatic clear_logs();
    res_y.delete();
    res_c.delete();
    drop_c.delete();
    sent_c.delete();
  endtask

  task automatic send(input logic [31:0] d);
    @(posedge clk);
    #1;
    x_vld = 1'b1;
    x     = d;
    sent_c.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      x_vld = 1'b0;
    end
  endtask

  logic [31:0] single_x [5];
  logic [15:0] single_y [5];
  logic [31:0] rv;
  int t0;

  initial begin
    single_x = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF};
    single_y = '{16'd0, 16'd1, 16'd3, 16'd4, 16'hFFFF};

    // Reset with x_vld asserted: the request must be ignored.
    rst = 1'b1; x_vld = 1'b1; x = 32'd81;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; x_vld = 1'b0;
    @(negedge clk);
    check("reset_y_vld", {63'd0, y_vld}, 64'd0);
    check("reset_y",     {48'd0, y},     64'd0);
    check("reset_busy",  {63'd0, busy},  64'd0);
    check("reset_drop",  {63'd0, drop},  64'd0);
    idle(20);
    check("reset_ignored_req", 64'(res_y.size()), 64'd0);

    // Single requests on an idle block.
    for (int i = 0; i < 5; i++) begin
      clear_logs();
      send(single_x[i]);
      idle(20);
      check($sformatf("single_count_%0d", i), 64'(res_y.size()), 64'd1);
      check($sformatf("single_y_%0d", i), got_y(0), {48'd0, single_y[i]});
      check($sformatf("single_lat_%0d", i), got_lat(0), 64'd17);
      check($sformatf("single_idle_busy_%0d", i), {63'd0, busy}, 64'd0);
    end

    // Three back-to-back requests.
    clear_logs();
    send(32'd100); send(32'd1000000); send(32'd2);
    idle(60);
    check("b2b_count", 64'(res_y.size()), 64'd3);
    check("b2b_y0", got_y(0), 64'd10);
    check("b2b_y1", got_y(1), 64'd1000);
    check("b2b_y2", got_y(2), 64'd1);
    check("b2b_lat0", got_lat(0), 64'd17);
    check("b2b_lat1", got_lat(1), 64'd34);
    check("b2b_lat2", got_lat(2), 64'd51);

    // Six consecutive requests: one bypass, four queued, sixth dropped.
    clear_logs();
    send(32'd4); send(32'd9); send(32'd25); send(32'd49); send(32'd81); send(32'd121);
    idle(100);
    check("full_drop_count", 64'(drop_c.size()), 64'd1);
    check("full_drop_cycle", (drop_c.size() > 0) ? 64'(drop_c[0] - sent_c[0]) : 64'hDEAD, 64'd5);
    check("full_res_count", 64'(res_y.size()), 64'd5);
    check("full_y0", got_y(0), 64'd2);
    check("full_y1", got_y(1), 64'd3);
    check("full_y2", got_y(2), 64'd5);
    check("full_y3", got_y(3), 64'd7);
    check("full_y4", got_y(4), 64'd9);
    check("full_lat4", got_lat(4), 64'd85);

    // Queue full and a new request in the DONE cycle: push and pop together.
    clear_logs();
    send(32'd144); send(32'd169); send(32'd196); send(32'd225); send(32'd256);
    idle(12);
    send(32'd289);
    check("pushpop_in_done", 64'(cyc - sent_c[0]), 64'd17);
    idle(110);
    check("pushpop_drop", 64'(drop_c.size()), 64'd0);
    check("pushpop_count", 64'(res_y.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("pushpop_y%0d", i), got_y(i), 64'(12 + i));
    check("pushpop_lat5", got_lat(5), 64'd102);

    // Reset at iteration 8 with two requests queued.
    clear_logs();
    send(32'd1000); send(32'd2000); send(32'd3000);
    idle(6);
    @(posedge clk);
    #1;
    t0 = sent_c[0];
    check("abort_at_iter8", 64'(cyc - t0), 64'd9);
    rst = 1'b1; x_vld = 1'b1; x = 32'd400;
    @(posedge clk);
    #1;
    rst = 1'b0; x_vld = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy},  64'd0);
    check("abort_y",    {48'd0, y},     64'd0);
    check("abort_y_vld",{63'd0, y_vld}, 64'd0);
    idle(60);
    check("abort_no_results", 64'(res_y.size()), 64'd0);
    clear_logs();
    send(32'd49);
    idle(20);
    check("post_abort_y", got_y(0), 64'd7);
    check("post_abort_lat", got_lat(0), 64'd17);

    // Randomized sparse traffic against the reference model.
    clear_logs();
    exp_y.delete();
    for (int i = 0; i < 200; i++) begin
      case (i % 4)
        0: rv = $urandom;
        1: begin rv = $urandom_range(65535, 0); rv = rv * rv; end
        2: begin rv = $urandom_range(65535, 1); rv = rv * rv - 1; end
        default: rv = $urandom_range(1000, 0);
      endcase
      exp_y.push_back(ref_isqrt(rv));
      send(rv);
      idle($urandom_range(22, 16));
    end
    idle(20);
    check("rand_count", 64'(res_y.size()), 64'd200);
    check("rand_drop", 64'(drop_c.size()), 64'd0);
    for (int i = 0; i < 200; i++)
      check($sformatf("rand_y%0d", i), got_y(i), {48'd0, exp_y[i]});
    for (int i = 0; i < 200; i++)
      check($sformatf("rand_lat%0d", i),
            (i < res_c.size()) ? 64'(res_c[i] - sent_c[i]) : 64'hDEAD, 64'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
